// File: rtl/stype_store_if.sv
// Store-unit bus: instruction handshake, register-file read ports,
// data-memory write port and completion status.
interface stype_store_if #(
    parameter int CNT_W = 16
);
    logic             instr_valid;
    logic             instr_ready;
    logic [31:0]      instr;
    logic [4:0]       rr1;
    logic [4:0]       rr2;
    logic [63:0]      rdata1;
    logic [63:0]      rdata2;
    logic             mem_wr;
    logic [63:0]      mem_addr;
    logic [63:0]      mem_wdata;
    logic [7:0]       mem_be;
    logic             mem_ack;
    logic             done;
    logic             error;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] store_count;

    modport slave (
        input  instr_valid, instr, rdata1, rdata2, mem_ack,
        output instr_ready, rr1, rr2, mem_wr, mem_addr, mem_wdata, mem_be,
               done, error, err_code, store_count
    );

    modport master (
        output instr_valid, instr, rdata1, rdata2, mem_ack,
        input  instr_ready, rr1, rr2, mem_wr, mem_addr, mem_wdata, mem_be,
               done, error, err_code, store_count
    );
endinterface

// File: rtl/stype_store_unit.sv
// Multi-cycle RISC-V S-type store executor: reads rs1/rs2, forms rs1 + sext(imm)
// and issues one lane-aligned byte-enabled write with ack/timeout.
module stype_store_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input logic          clk,
    input logic          rst,
    stype_store_if.slave bus
);
    localparam int               TMO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [6:0]       OPC_STORE = 7'b0100011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_ADDR,
        S_MEM,
        S_DONE
    } state_t;

    state_t           state;
    logic [TMO_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] cnt_q;

    logic [11:0]      imm_raw_p0;
    logic [2:0]       funct3_p0;
    logic [6:0]       opcode_p0;
    logic [63:0]      base_p0;
    logic [63:0]      sdata_p0;

    logic signed [63:0] imm_p1;
    logic [63:0]        addr_p1;
    logic               illegal_p1;
    logic               misaligned_p1;
    logic [7:0]         be_p1;
    logic [63:0]        wdata_p1;

    function automatic logic signed [63:0] sext12(input logic [11:0] v);
        return {{52{v[11]}}, v};
    endfunction

    function automatic logic misaligned_for(input logic [1:0] sz, input logic [2:0] off);
        logic m;
        case (sz)
            2'd0:    m = 1'b0;
            2'd1:    m = off[0];
            2'd2:    m = |off[1:0];
            default: m = |off;
        endcase
        return m;
    endfunction

    function automatic logic [7:0] lane_be(input logic [1:0] sz, input logic [2:0] off);
        logic [7:0] m;
        case (sz)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << off;
    endfunction

    function automatic logic [63:0] lane_data(input logic [63:0] d, input logic [2:0] off);
        return d << {off, 3'b000};
    endfunction

    // ADDR stage: effective address, legality and lane placement
    always_comb begin
        imm_p1        = sext12(imm_raw_p0);
        addr_p1       = base_p0 + $unsigned(imm_p1);
        illegal_p1    = (opcode_p0 != OPC_STORE) || funct3_p0[2];
        misaligned_p1 = misaligned_for(funct3_p0[1:0], addr_p1[2:0]);
        be_p1         = lane_be(funct3_p0[1:0], addr_p1[2:0]);
        wdata_p1      = lane_data(sdata_p0, addr_p1[2:0]);
    end

    // Instruction fields and operands carry no reset; they are always written before use
    always_ff @(posedge clk) begin
        if (state == S_IDLE && bus.instr_valid) begin
            imm_raw_p0 <= {bus.instr[31:25], bus.instr[11:7]};
            funct3_p0  <= bus.instr[14:12];
            opcode_p0  <= bus.instr[6:0];
        end
        if (state == S_READ) begin
            base_p0  <= bus.rdata1;
            sdata_p0 <= bus.rdata2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            tmo_cnt         <= '0;
            cnt_q           <= '0;
            bus.instr_ready <= 1'b1;
            bus.rr1         <= '0;
            bus.rr2         <= '0;
            bus.mem_wr      <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_wdata   <= '0;
            bus.mem_be      <= '0;
            bus.done        <= 1'b0;
            bus.error       <= 1'b0;
            bus.err_code    <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.instr_valid) begin
                        bus.rr1         <= bus.instr[19:15];
                        bus.rr2         <= bus.instr[24:20];
                        bus.error       <= 1'b0;
                        bus.err_code    <= 2'b00;
                        bus.instr_ready <= 1'b0;
                        state           <= S_READ;
                    end
                end
                S_READ: begin
                    state <= S_ADDR;
                end
                S_ADDR: begin
                    if (illegal_p1 || misaligned_p1) begin
                        bus.error    <= 1'b1;
                        bus.err_code <= illegal_p1 ? 2'b01 : 2'b10;
                        bus.done     <= 1'b1;
                        state        <= S_DONE;
                    end else begin
                        bus.mem_addr  <= addr_p1;
                        bus.mem_be    <= be_p1;
                        bus.mem_wdata <= wdata_p1;
                        bus.mem_wr    <= 1'b1;
                        tmo_cnt       <= '0;
                        state         <= S_MEM;
                    end
                end
                S_MEM: begin
                    // An ack in the final allowed cycle still counts as success
                    if (bus.mem_ack) begin
                        bus.mem_wr <= 1'b0;
                        cnt_q      <= cnt_q + 1'b1;
                        bus.done   <= 1'b1;
                        state      <= S_DONE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        bus.mem_wr   <= 1'b0;
                        bus.error    <= 1'b1;
                        bus.err_code <= 2'b11;
                        bus.done     <= 1'b1;
                        state        <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    bus.done        <= 1'b0;
                    bus.instr_ready <= 1'b1;
                    state           <= S_IDLE;
                end
                default: begin
                    state           <= S_IDLE;
                    bus.instr_ready <= 1'b1;
                    bus.mem_wr      <= 1'b0;
                    bus.done        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.store_count = cnt_q;

endmodule

// File: tb/tb_stype_store_unit.sv
// Randomized self-checking bench for stype_store_unit against a behavioural store model.
module tb_stype_store_unit;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 4;

    logic clk;
    logic rst;
    logic [63:0] regs [32];
    int n_checks;
    int n_fail;
    int exp_count;

    stype_store_if #(.CNT_W(CNT_W)) bus ();

    stype_store_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    assign bus.rdata1 = regs[bus.rr1];
    assign bus.rdata2 = regs[bus.rr2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_s(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
    endfunction

    // Reference: outcome of one store from the architectural rules
    task automatic model(input logic [31:0] ins, input int ack_delay,
                         output logic [1:0] e_code, output logic [63:0] e_addr,
                         output logic [7:0] e_be, output logic [63:0] e_wdata,
                         output int e_lat, output int e_memcyc);
        logic signed [11:0] imm12;
        logic signed [63:0] imm64;
        int size;
        int off;
        imm12  = {ins[31:25], ins[11:7]};
        imm64  = imm12;
        e_addr = regs[ins[19:15]] + imm64;
        size   = 1 << ins[14:12];
        off    = int'(e_addr & 64'd7);
        e_be    = 8'(((1 << size) - 1) << off);
        e_wdata = regs[ins[24:20]] << (8 * off);
        if (ins[6:0] != 7'b0100011 || ins[14:12] > 3'd3)      e_code = 2'b01;
        else if ((e_addr % 64'(size)) != 64'd0)              e_code = 2'b10;
        else if (ack_delay < 0 || ack_delay >= TIMEOUT)      e_code = 2'b11;
        else                                                 e_code = 2'b00;
        case (e_code)
            2'b00:   begin e_lat = 4 + ack_delay; e_memcyc = ack_delay + 1; end
            2'b11:   begin e_lat = 3 + TIMEOUT;   e_memcyc = TIMEOUT;       end
            default: begin e_lat = 3;             e_memcyc = 0;             end
        endcase
    endtask

    task automatic run_store(input string tag, input logic [31:0] ins, input int ack_delay);
        logic [1:0]  e_code;
        logic [63:0] e_addr;
        logic [7:0]  e_be;
        logic [63:0] e_wdata;
        int e_lat;
        int e_memcyc;
        int lat;
        int memcyc;
        int waited;
        logic stable;
        logic seen;
        model(ins, ack_delay, e_code, e_addr, e_be, e_wdata, e_lat, e_memcyc);
        waited = 0;
        while (!bus.instr_ready && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check({tag, "/ready"}, 64'(bus.instr_ready), 64'd1);
        @(negedge clk);
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        lat    = 1;
        memcyc = 0;
        stable = 1'b1;
        seen   = 1'b0;
        check({tag, "/rr1"}, 64'(bus.rr1), 64'(ins[19:15]));
        check({tag, "/rr2"}, 64'(bus.rr2), 64'(ins[24:20]));
        while (!seen && lat < 64) begin
            @(negedge clk);
            if (bus.mem_wr) begin
                if (memcyc == 0 && (e_code == 2'b00 || e_code == 2'b11)) begin
                    check({tag, "/addr"},  bus.mem_addr, e_addr);
                    check({tag, "/be"},    64'(bus.mem_be), 64'(e_be));
                    check({tag, "/wdata"}, bus.mem_wdata, e_wdata);
                end else if (bus.mem_addr !== e_addr || bus.mem_be !== e_be ||
                             bus.mem_wdata !== e_wdata) begin
                    stable = 1'b0;
                end
                bus.mem_ack = (memcyc == ack_delay);
                memcyc++;
            end else begin
                bus.mem_ack = 1'($urandom_range(0, 1));
            end
            bus.instr_valid = 1'($urandom_range(0, 1));
            bus.instr       = $urandom;
            @(posedge clk);
            #1;
            lat++;
            seen = bus.done;
        end
        bus.instr_valid = 1'b0;
        bus.mem_ack     = 1'b0;
        if (e_code == 2'b00) exp_count++;
        check({tag, "/done_seen"}, 64'(seen), 64'd1);
        check({tag, "/latency"},   64'(lat), 64'(e_lat));
        check({tag, "/wr_cycles"}, 64'(memcyc), 64'(e_memcyc));
        check({tag, "/stable"},    64'(stable), 64'd1);
        check({tag, "/error"},     64'(bus.error), 64'(e_code != 2'b00));
        check({tag, "/err_code"},  64'(bus.err_code), 64'(e_code));
        check({tag, "/count"},     64'(bus.store_count), 64'(exp_count % (1 << CNT_W)));
        @(posedge clk);
        #1;
        check({tag, "/done_pulse"}, 64'(bus.done), 64'd0);
        check({tag, "/ready_after"}, 64'(bus.instr_ready), 64'd1);
        check({tag, "/err_hold"},   64'(bus.err_code), 64'(e_code));
    endtask

    initial begin
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [6:0]  op;
        int          ad;
        int          waited;
        n_checks  = 0;
        n_fail    = 0;
        exp_count = 0;
        for (int r = 0; r < 32; r++) regs[r] = 64'd0;
        bus.instr_valid = 1'b0;
        bus.instr       = 32'd0;
        bus.mem_ack     = 1'b0;
        rst = 1'b1;
        #1;
        check("rst/ready",    64'(bus.instr_ready), 64'd1);
        check("rst/mem_wr",   64'(bus.mem_wr), 64'd0);
        check("rst/mem_addr", bus.mem_addr, 64'd0);
        check("rst/mem_be",   64'(bus.mem_be), 64'd0);
        check("rst/rr1",      64'(bus.rr1), 64'd0);
        check("rst/done",     64'(bus.done), 64'd0);
        check("rst/err_code", 64'(bus.err_code), 64'd0);
        check("rst/count",    64'(bus.store_count), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        regs[5] = 64'h1000;
        regs[6] = 64'hDEADBEEF_CAFEF00D;
        run_store("sd", mk_s(7'h23, 3'd3, 5'd5, 5'd6, 12'd8), 0);
        regs[7] = 64'h2003;
        regs[8] = 64'hAB;
        run_store("sb", mk_s(7'h23, 3'd0, 5'd7, 5'd8, 12'd0), 1);
        run_store("sw_mis", mk_s(7'h23, 3'd2, 5'd0, 5'd6, 12'hFFE), 0);
        regs[9] = 64'h100;
        run_store("f3_100", mk_s(7'h23, 3'd4, 5'd9, 5'd6, 12'd0), 0);
        regs[10] = 64'h1;
        run_store("op_ill", mk_s(7'h13, 3'd2, 5'd10, 5'd6, 12'd0), 0);
        regs[11] = 64'h3000;
        regs[12] = 64'h1234_5678_9ABC_DEF1;
        run_store("sh_tmo", mk_s(7'h23, 3'd1, 5'd11, 5'd12, 12'h006), -1);
        run_store("sh_ack16", mk_s(7'h23, 3'd1, 5'd11, 5'd12, 12'h006), TIMEOUT - 1);

        // Reset while a write is outstanding
        waited = 0;
        while (!bus.instr_ready && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        @(negedge clk);
        bus.instr       = mk_s(7'h23, 3'd1, 5'd11, 5'd12, 12'h002);
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        check("mrst/pre_wr", 64'(bus.mem_wr), 64'd1);
        rst = 1'b1;
        #1;
        exp_count = 0;
        check("mrst/mem_wr", 64'(bus.mem_wr), 64'd0);
        check("mrst/ready",  64'(bus.instr_ready), 64'd1);
        check("mrst/count",  64'(bus.store_count), 64'd0);
        check("mrst/done",   64'(bus.done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        regs[13] = 64'h2000;
        run_store("sd_post", mk_s(7'h23, 3'd3, 5'd13, 5'd6, 12'hFF8), 0);

        for (int i = 0; i < 200; i++) begin
            for (int r = 1; r < 32; r++) regs[r] = {$urandom, $urandom};
            rs1 = 5'($urandom_range(0, 31));
            rs2 = 5'($urandom_range(0, 31));
            f3  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            imm = 12'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                if (rs1 != 5'd0) regs[rs1][2:0] = 3'd0;
                imm[2:0] = 3'd0;
            end
            op = ($urandom_range(0, 15) == 0) ? 7'h13 : 7'h23;
            ad = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 3));
            run_store("rand", mk_s(op, f3, rs1, rs2, imm), ad);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
